lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised LIFO stack, the next generation of the team's 8x8 stack primitive. It adds configurable width and depth, a registered pop-data valid strobe and a registered top-of-stack peek. It also supports push and pop in the same cycle (replace-top), an occupancy count with an almost-full level, and sticky overflow/underflow error flags. It sits between a producer and a consumer that share one clock, for example call/return or scope tracking in control datapaths.

## Interface
- `WIDTH`, default 8: data width in bits, ≥1.
- `DEPTH`, default 8: number of entries, ≥2. Any value is allowed; a power of two is not required.
- `AF_LEVEL`, default DEPTH-1: `almost_full` threshold, 1..DEPTH.
- `CW` (localparam): $clog2(DEPTH+1), the count width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `din`  in  WIDTH  data to push.
- `err_clr`  in  1  clears the sticky error flags.
- `dout`  out  WIDTH  popped data, registered.
- `dout_valid`  out  1  one-cycle strobe; `dout` is valid.
- `top`  out  WIDTH  current top-of-stack (peek), registered.
- `count`  out  CW  number of stored entries, 0..DEPTH.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `overflow`  out  1  sticky: a push was attempted while full and no pop was issued.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Storage is a DEPTH x WIDTH array. The write pointer equals `count`; the top entry is at index count-1. Array contents are not reset.
- Push only, not full: write `din` to mem[count], count+1, `top` <= `din`.
- Pop only, not empty:
  - `dout` <= `top`, `dout_valid` <= 1, count-1.
  - `top` <= mem[count-2], or 0 if the stack becomes empty.
- Push and pop together, not empty (including full):
  - Replace-top: `dout` <= `top`, `dout_valid` <= 1.
  - mem[count-1] <= `din`, `top` <= `din`, count unchanged. No overflow is flagged.
- Push and pop together, empty: the push is performed as a push-only operation. The pop is ignored, `dout_valid` stays 0 and `underflow` is set.
- Push only, full: ignored, with no state change, and `overflow` is set.
- Pop only, empty: ignored, `dout` holds its value, `dout_valid` stays 0 and `underflow` is set.
- `dout` holds its last popped value until the next valid pop.
- Error flags:
  - Set-dominant over `err_clr`: if an error and `err_clr` occur in the same cycle, the flag remains 1.
  - `err_clr` clears a flag only in a cycle with no new error.
- No FSM; the block's state is `count`, `top`, `dout`, `dout_valid`, the array and the error flags.
- Count arithmetic is CW bits. Increments and decrements happen only under the guards above, so `count` never wraps.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from `push`, `pop` or `din` to any output.
- Pop latency is 1 cycle: the pop is sampled at edge N and `dout`/`dout_valid` are valid after edge N.
- `top`, `count`, `empty`, `full` and `almost_full` reflect the operation sampled at edge N immediately after edge N.
- Back-to-back pushes or pops are accepted every cycle, giving full throughput.
- Reset values, applied when `rst` is high at an edge:
  - `count`=0, `top`=0, `dout`=0, `dout_valid`=0, `overflow`=0, `underflow`=0.
  - This gives `empty`=1, `full`=0, and `almost_full`=0 (AF_LEVEL ≥ 1).
- Reset mid-operation takes priority over `push`/`pop` in the same cycle. Prior contents are logically discarded.

## Configuration
- `LIFO_STACK_ERR_EN` defined: the overflow/underflow sticky flag logic and `err_clr` handling are compiled in as described above.
- `LIFO_STACK_ERR_EN` undefined:
  - `overflow` and `underflow` are tied to 0 and `err_clr` is ignored.
  - Illegal pushes and pops are still ignored identically, so datapath behaviour is unchanged.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, top=0x33. Then pop three cycles -> dout 0x33, 0x22, 0x11 with dout_valid high each cycle, ending with empty=1 and top=0.
- DEPTH=8: push 8 values -> full=1, almost_full=1 from count=7. A 9th push -> count stays 8, top is unchanged, overflow=1 (when ERR_EN is defined). Then err_clr -> overflow=0.
- When full, push=pop=1 with din=0xAA -> dout=previous top, dout_valid=1, top=0xAA, count=8, overflow=0.
- When empty, push=pop=1 with din=0x5C -> count=1, top=0x5C, dout_valid=0, underflow=1. A pop when empty with ERR_EN undefined -> underflow=0.
- Push 4 values, then assert rst together with push=1 -> count=0, top=0, dout=0, empty=1. The next push 0x77 -> count=1, top=0x77.
- Error precedence: pop when empty with err_clr=1 in the same cycle -> underflow=1. The following cycle, err_clr alone -> underflow=0.

Source files
------------

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with registered pop data, top-of-stack peek, occupancy and almost-full.
// Define LIFO_STACK_ERR_EN to compile in the sticky overflow/underflow flags and err_clr handling.
module lifo_stack #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_m1;
  logic [CW-1:0]    cnt_m2;
  logic             do_replace;
  logic             do_push;
  logic             do_pop;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));

  assign cnt_m1 = count - CW'(1);
  assign cnt_m2 = count - CW'(2);

  // A push alongside a pop on an empty stack degrades to a plain push.
  assign do_replace = push && pop && !empty;
  assign do_push    = push && !do_replace && !full;
  assign do_pop     = pop && !push && !empty;

  assign mem_we    = do_replace || do_push;
  assign mem_waddr = do_replace ? cnt_m1[AW-1:0] : count[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      top        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (do_replace) begin
        dout       <= top;
        dout_valid <= 1'b1;
        top        <= din;
      end else if (do_push) begin
        top   <= din;
        count <= count + CW'(1);
      end else if (do_pop) begin
        dout       <= top;
        dout_valid <= 1'b1;
        count      <= cnt_m1;
        // The entry below the current top becomes visible, or zero once drained.
        top        <= (count >= CW'(2)) ? mem[cnt_m2[AW-1:0]] : '0;
      end
    end
  end

`ifdef LIFO_STACK_ERR_EN
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = push && !pop && full;
  assign unf_evt = pop && empty;

  // New errors win over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (unf_evt)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed vector table, corner sequences, and
// randomized traffic compared against a queue-based reference model.
module tb_lifo_stack;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = DEPTH - 1;
  localparam int CW       = $clog2(DEPTH + 1);
`ifdef LIFO_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, push, pop, err_clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout, top;
  logic             dout_valid, empty, full, almost_full, overflow, underflow;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .dout(dout), .dout_valid(dout_valid), .top(top), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dv, m_ovf, m_unf;

  function automatic logic [WIDTH-1:0] modelTop();
    return (stk.size() == 0) ? '0 : stk[stk.size()-1];
  endfunction

  task automatic modelStep(input logic r, input logic pu, input logic po,
                           input logic [WIDTH-1:0] d, input logic clr);
    logic newOvf, newUnf;
    if (r) begin
      stk.delete();
      m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    newOvf = pu && !po && (stk.size() == DEPTH);
    newUnf = po && (stk.size() == 0);
    m_dv = 0;
    if (pu && po && stk.size() > 0) begin
      m_dout = stk[stk.size()-1];
      m_dv = 1;
      stk[stk.size()-1] = d;
    end else if (pu && stk.size() < DEPTH) begin
      stk.push_back(d);
    end else if (po && !pu && stk.size() > 0) begin
      m_dout = stk.pop_back();
      m_dv = 1;
    end
    if (ERR) begin
      m_ovf = newOvf ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = newUnf ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".count"}, 32'(count), 32'(stk.size()));
    checkVal({tag, ".top"}, 32'(top), 32'(modelTop()));
    checkVal({tag, ".dout"}, 32'(dout), 32'(m_dout));
    checkVal({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_dv));
    checkVal({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
    checkVal({tag, ".full"}, 32'(full), 32'(stk.size() == DEPTH));
    checkVal({tag, ".almost_full"}, 32'(almost_full), 32'(stk.size() >= AF_LEVEL));
    checkVal({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    checkVal({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic applyStimulus(input logic r, input logic pu, input logic po,
                               input logic [WIDTH-1:0] d, input logic clr);
    rst = r; push = pu; pop = po; din = d; err_clr = clr;
    @(posedge clk);
    modelStep(r, pu, po, d, clr);
    #1;
    rst = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  typedef struct {
    logic             r, pu, po;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    eCount;
    logic [WIDTH-1:0] eTop, eDout;
    logic             eDv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1; push = 0; pop = 0; din = '0; err_clr = 0;
    stk.delete(); m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;

    // Basic push/pop ordering with hand-computed expectations.
    vecs.push_back('{1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0});
    vecs.push_back('{0, 1, 0, 8'h11, 1, 8'h11, 8'h00, 0});
    vecs.push_back('{0, 1, 0, 8'h22, 2, 8'h22, 8'h00, 0});
    vecs.push_back('{0, 1, 0, 8'h33, 3, 8'h33, 8'h00, 0});
    vecs.push_back('{0, 0, 1, 8'h00, 2, 8'h22, 8'h33, 1});
    vecs.push_back('{0, 0, 1, 8'h00, 1, 8'h11, 8'h22, 1});
    vecs.push_back('{0, 0, 1, 8'h00, 0, 8'h00, 8'h11, 1});
    vecs.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h11, 0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].pu, vecs[i].po, vecs[i].d, 0);
      checkVal($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].eCount));
      checkVal($sformatf("vec%0d.top", i), 32'(top), 32'(vecs[i].eTop));
      checkVal($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].eDout));
      checkVal($sformatf("vec%0d.dv", i), 32'(dout_valid), 32'(vecs[i].eDv));
    end
    checkVal("seq1.empty", 32'(empty), 32'd1);

    // Fill to full, watching almost_full and full.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, 0, 8'(8'hA0 + i), 0);
      checkVal($sformatf("fill%0d.af", i), 32'(almost_full), 32'(i + 1 >= 7));
      checkVal($sformatf("fill%0d.full", i), 32'(full), 32'(i + 1 == 8));
    end
    applyStimulus(0, 1, 0, 8'hEE, 0);
    checkVal("ovf.count", 32'(count), 32'd8);
    checkVal("ovf.top", 32'(top), 32'hA7);
    checkVal("ovf.flag", 32'(overflow), 32'(ERR));
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkVal("ovf.clr", 32'(overflow), 32'd0);

    // Replace-top while full.
    applyStimulus(0, 1, 1, 8'hAA, 0);
    checkVal("rep.dout", 32'(dout), 32'hA7);
    checkVal("rep.dv", 32'(dout_valid), 32'd1);
    checkVal("rep.top", 32'(top), 32'hAA);
    checkVal("rep.count", 32'(count), 32'd8);
    checkVal("rep.ovf", 32'(overflow), 32'd0);
    applyStimulus(0, 0, 1, 8'h00, 0);
    checkVal("rep.pop", 32'(dout), 32'hAA);
    checkVal("rep.newtop", 32'(top), 32'hA6);

    // Push+pop on an empty stack acts as a push and flags underflow.
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'h5C, 0);
    checkVal("epp.count", 32'(count), 32'd1);
    checkVal("epp.top", 32'(top), 32'h5C);
    checkVal("epp.dv", 32'(dout_valid), 32'd0);
    checkVal("epp.unf", 32'(underflow), 32'(ERR));

    // Reset wins over a simultaneous push.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'(8'h40 + i), 0);
    applyStimulus(0, 0, 1, 8'h00, 0);
    applyStimulus(1, 1, 0, 8'h99, 0);
    checkVal("rst.count", 32'(count), 32'd0);
    checkVal("rst.top", 32'(top), 32'd0);
    checkVal("rst.dout", 32'(dout), 32'd0);
    checkVal("rst.empty", 32'(empty), 32'd1);
    checkVal("rst.unf", 32'(underflow), 32'd0);
    applyStimulus(0, 1, 0, 8'h77, 0);
    checkVal("rst.push.count", 32'(count), 32'd1);
    checkVal("rst.push.top", 32'(top), 32'h77);

    // Error set dominates a simultaneous clear; clear alone then works.
    applyStimulus(0, 0, 1, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h00, 1);
    checkVal("prec.set", 32'(underflow), 32'(ERR));
    checkVal("prec.dout", 32'(dout), 32'h77);
    checkVal("prec.dv", 32'(dout_valid), 32'd0);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkVal("prec.clr", 32'(underflow), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 55,
                    $urandom_range(0, 99) < 45, 8'($urandom),
                    $urandom_range(0, 9) == 0);
      checkOutput($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
